// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
// Holds the FSM state enum, the supported opcodes, the ALU_Control codes,
// and the encodings of every datapath select the controller drives.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
// master: the controller (takes instruction fields and Zero, drives selects/enables).
// slave : the datapath (supplies instruction fields and Zero, consumes controls).
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] ALU_Control;
  logic       illegal_instr;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALU_Control, illegal_instr
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALU_Control, illegal_instr
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps (alu_op, funct3, funct7b5, op[5]) to the 3-bit ALU_Control.
// Ports: alu_op, funct3, funct7b5, op5 in; alu_control out. Purely combinational.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op[5] separates R-type from I-type: addi never subtracts,
          // even when imm[10] happens to sit in the funct7b5 position.
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multi-cycle RV32I subset
// (lw, sw, R-type, I-type ALU, beq, jal).
// Ports: clk, reset (synchronous, active high), bus (master modport:
// instruction fields + Zero in; mux selects, write enables, ALU_Control,
// illegal_instr out).
//
// state    | meaning
// ---------+----------------------------------------------------
// FETCH    | load IR from mem[PC], PC <= PC + 4
// DECODE   | read registers, ALUOut <= OldPC + imm (branch target)
// MEMADR   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= loaded data
// MEMWRITE | write rs2 to data memory at ALUOut
// EXECUTER | ALUOut <= rs1 op rs2
// EXECUTEI | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BEQ      | compare rs1/rs2; PC <= target when equal
// JAL      | PC <= target, ALUOut <= OldPC + 4 (link value)
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  multicycle_controller_if.master  bus
);

  state_t     state;
  state_t     state_next;
  alu_op_t    alu_op;
  logic       pc_update;
  logic       branch;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       illegal;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       op_legal;

  assign op_legal = (bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_R) ||
                    (bus.op == OP_I)  || (bus.op == OP_BEQ) || (bus.op == OP_JAL);

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        pc_update  = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if      (bus.op == OP_LW || bus.op == OP_SW) state_next = S_MEMADR;
        else if (bus.op == OP_R)                     state_next = S_EXECUTER;
        else if (bus.op == OP_I)                     state_next = S_EXECUTEI;
        else if (bus.op == OP_BEQ)                   state_next = S_BEQ;
        else if (bus.op == OP_JAL)                   state_next = S_JAL;
        else                                         state_next = S_FETCH;
        illegal = !op_legal;
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    imm_src = IMM_I;
    case (bus.op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (alu_control)
  );

  // Write enables are masked while reset is high so that an instruction
  // aborted by reset never commits anything, even in the reset cycle itself.
  assign bus.PCWrite       = !reset && (pc_update || (branch && bus.Zero));
  assign bus.MemWrite      = !reset && mem_write;
  assign bus.IRWrite       = !reset && ir_write;
  assign bus.RegWrite      = !reset && reg_write;
  assign bus.illegal_instr = !reset && illegal;
  assign bus.AdrSrc        = adr_src;
  assign bus.ResultSrc     = result_src;
  assign bus.ALUSrcA       = alu_src_a;
  assign bus.ALUSrcB       = alu_src_b;
  assign bus.ImmSrc        = imm_src;
  assign bus.ALU_Control   = alu_control;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multi-cycle RV32I core subset: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal. It is the producer side of the ALU interface: it generates the 3-bit ALU_Control code the ALU consumes and takes back the ALU's Zero flag for branch resolution. A Moore FSM sequences fetch, decode, execute, memory and writeback, and drives all datapath mux selects and write enables.

Parameters:
none (fixed RV32I subset; no configurable widths)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
op  in  7  instr[6:0], sampled from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
Zero  in  1  ALU zero flag, same cycle as ALU_Control
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register enable
ResultSrc  out  2  result mux: 00=ALUOut, 01=Data, 10=ALU result
ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1 data
ALUSrcB  out  2  ALU B select: 00=rs2 data, 01=ImmExt, 10=constant 4
ImmSrc  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
RegWrite  out  1  register file write enable
ALU_Control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal_instr  out  1  one-cycle pulse in DECODE for an unsupported op

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Transitions:
  - FETCH->DECODE.
  - DECODE: lw/sw (0000011/0100011)->MEMADR; R (0110011)->EXECUTER; I (0010011)->EXECUTEI; beq (1100011)->BEQ; jal (1101111)->JAL; any other op->FETCH with illegal_instr=1.
  - MEMADR: ->MEMREAD if op=lw, else ->MEMWRITE.
  - MEMREAD->MEMWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
  - EXECUTER, EXECUTEI, JAL->ALUWB.
- Outputs per state. Unlisted outputs are 0.
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1, ALUOp=00.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- PCWrite = PCUpdate | (Branch & Zero). This is the only combinational path from an input to a write enable.
- ImmSrc is decoded combinationally from op in every state: lw/I=00, sw=01, beq=10, jal=11, other=00.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 with funct3=000: sub if op[5]&funct7b5, else add.
  - ALUOp 10 with funct3 010->slt, 110->or, 111->and; any other funct3->add (000).
- Reset: clk edge with reset=1 loads FETCH. While reset is high, PCWrite, MemWrite, IRWrite, RegWrite and illegal_instr are forced to 0; the other outputs are don't-care.
- Reset mid-instruction aborts with no further writes. The first cycle after reset deasserts is FETCH.
- Latencies (cycles/instr): lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2.
- op/funct are held by the IR (IRWrite only in FETCH), so they are stable from DECODE to the end of the instruction.

Decomposition:
- Shared package holds:
  - state enum;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - ALU_Control codes (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101);
  - ALUOp, ImmSrc, ResultSrc and src-select encodings.
- One combinational sub-module, alu_decoder: (ALUOp, funct3, funct7b5, op[5]) -> ALU_Control.
- FSM, output decode and ImmSrc stay in multicycle_controller.

Test Plan:
- reset 2 cycles, then op=0000011 (lw) -> state path FETCH,DECODE,MEMADR,MEMREAD,MEMWB. IRWrite=1 only in cycle 1, AdrSrc=1 in cycle 4, RegWrite=1 with ResultSrc=01 in cycle 5, then FETCH.
- sw (0100011) -> MemWrite=1 exactly once in cycle 4, ImmSrc=01, RegWrite never 1.
- R-type, funct3=000, funct7b5=1 -> ALU_Control=001 in EXECUTER. funct3=111 gives 010, 110 gives 011, 010 gives 101. addi with funct7b5=1 (op[5]=0) gives 000.
- beq with Zero=1 in BEQ -> PCWrite=1, ImmSrc=10, ALU_Control=001. Repeat with Zero=0 -> PCWrite=0. Both return to FETCH next cycle.
- jal -> JAL state has PCWrite=1, ALUSrcA=01, ALUSrcB=10, ImmSrc=11. ALUWB next has RegWrite=1.
- op=1111111 -> illegal_instr pulses once in DECODE, FETCH follows. Reset asserted in MEMREAD -> MemWrite/RegWrite stay 0 and the first post-reset state is FETCH.
